// File: rtl/parking_meter_ctrl.sv
// Parking meter: coin sync/edge detect, saturating credit, 1-unit tick,
// EXPIRED flash. Ports: clk, rst_n, coin_5, coin_10 -> time_val, expired, blank, state_o.
module parking_meter_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int FLASH_DIV = 25_000_000,
  parameter int MAX_TIME  = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [7:0] time_val,
  output logic       expired,
  output logic       blank,
  output logic [1:0] state_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10,
    BAD     = 2'b11
  } state_t;

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [FW-1:0]   fcnt;
  logic            c5_s1, c5_s2, c5_d, add5;
  logic            c10_s1, c10_s2, c10_d, add10;
  logic            any_add;
  logic [4:0]      amt;
  logic [8:0]      sum9;
  logic [7:0]      sat;

  assign state_o = state;

  // Synchronizers plus registered edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c5_s1  <= 1'b0;
      c5_s2  <= 1'b0;
      c5_d   <= 1'b0;
      add5   <= 1'b0;
      c10_s1 <= 1'b0;
      c10_s2 <= 1'b0;
      c10_d  <= 1'b0;
      add10  <= 1'b0;
    end else begin
      c5_s1  <= coin_5;
      c5_s2  <= c5_s1;
      c5_d   <= c5_s2;
      add5   <= c5_s2 & ~c5_d;
      c10_s1 <= coin_10;
      c10_s2 <= c10_s1;
      c10_d  <= c10_s2;
      add10  <= c10_s2 & ~c10_d;
    end
  end

  always_comb begin
    any_add = add5 | add10;
    amt     = (add5 ? 5'd5 : 5'd0) + (add10 ? 5'd10 : 5'd0);
    sum9    = {1'b0, time_val} + {4'b0, amt};
    sat     = (sum9 > 9'(MAX_TIME)) ? 8'(MAX_TIME) : sum9[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      time_val <= 8'd0;
      expired  <= 1'b0;
      blank    <= 1'b0;
      tcnt     <= '0;
      fcnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt     <= '0;
          fcnt     <= '0;
          blank    <= 1'b0;
          expired  <= 1'b0;
          time_val <= 8'd0;
          if (any_add) begin
            state    <= RUN;
            time_val <= sat;
          end
        end
        RUN: begin
          fcnt    <= '0;
          blank   <= 1'b0;
          expired <= 1'b0;
          // An add pulse beats a coincident tick.
          if (any_add) begin
            time_val <= sat;
            tcnt     <= '0;
          end else if (tcnt == TMAX) begin
            tcnt <= '0;
            if (time_val <= 8'd1) begin
              time_val <= 8'd0;
              state    <= EXPIRED;
              expired  <= 1'b1;
            end else begin
              time_val <= time_val - 8'd1;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        EXPIRED: begin
          tcnt     <= '0;
          time_val <= 8'd0;
          expired  <= 1'b1;
          if (any_add) begin
            state    <= RUN;
            time_val <= sat;
            expired  <= 1'b0;
            blank    <= 1'b0;
            fcnt     <= '0;
          end else if (fcnt == FMAX) begin
            fcnt  <= '0;
            blank <= ~blank;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          time_val <= 8'd0;
          expired  <= 1'b0;
          blank    <= 1'b0;
          tcnt     <= '0;
          fcnt     <= '0;
        end
      endcase
    end
  end

endmodule
